// File: rtl/poly_job_scheduler.sv
// poly_job_scheduler: two-requester arbiter that sequences a shared datapath to compute a+b*x+c*x^2
module poly_job_scheduler #(
    parameter int W          = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [4*W-1:0] req_data0,
    input  logic [4*W-1:0] req_data1,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [W-1:0]   res_data,
    output logic           res_id,
    output logic           busy,
    output logic [7:0]     job_count,
    output logic [W-1:0]   dp_data_in,
    output logic           dp_ld_a,
    output logic           dp_ld_b,
    output logic           dp_ld_c,
    output logic           dp_ld_x,
    output logic           dp_ld_r,
    output logic           dp_ld_alu_out,
    output logic [1:0]     dp_sel_a,
    output logic [1:0]     dp_sel_b,
    output logic           dp_alu_op,
    input  logic [W-1:0]   dp_data_result
);
    typedef enum logic [3:0] {IDLE, LD_A, LD_B, LD_C, LD_X, C0, C1, C2, C3, C4, RESP} state_t;
    state_t         state_q, state_d;
    logic [4*W-1:0] job_q, job_d;
    logic           id_q, id_d;
    logic           last_grant_q, last_grant_d;
    logic [7:0]     job_count_q, job_count_d;
    logic           grant, accept;
    logic [W-1:0]   a, b, c, x;
    always_comb begin
        {a, b, c, x} = job_q;
        // a lone requester wins; a tie goes to whoever was not served last
        grant = (req_valid == 2'b10) || (req_valid == 2'b11 && !FIXED_PRIO && !last_grant_q);
        accept = state_q == IDLE && |req_valid;
        req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
        job_d = accept ? (grant ? req_data1 : req_data0) : job_q;
        id_d = accept ? grant : id_q;
        last_grant_d = accept ? grant : last_grant_q;
        res_valid = state_q == RESP;
        res_data = res_valid ? dp_data_result : '0;
        res_id = res_valid & id_q;
        busy = state_q != IDLE;
        job_count = job_count_q;
        job_count_d = job_count_q + {7'd0, res_valid & res_ready};
        dp_data_in = '0;
        dp_ld_a = 1'b0;
        dp_ld_b = 1'b0;
        dp_ld_c = 1'b0;
        dp_ld_x = 1'b0;
        dp_ld_r = 1'b0;
        dp_ld_alu_out = 1'b0;
        dp_sel_a = 2'd0;
        dp_sel_b = 2'd0;
        dp_alu_op = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: state_d = accept ? LD_A : IDLE;
            LD_A: begin
                dp_data_in = a;
                dp_ld_a = 1'b1;
                state_d = LD_B;
            end
            LD_B: begin
                dp_data_in = b;
                dp_ld_b = 1'b1;
                state_d = LD_C;
            end
            LD_C: begin
                dp_data_in = c;
                dp_ld_c = 1'b1;
                state_d = LD_X;
            end
            LD_X: begin
                dp_data_in = x;
                dp_ld_x = 1'b1;
                state_d = C0;
            end
            C0: begin
                dp_ld_b = 1'b1;
                dp_ld_alu_out = 1'b1;
                dp_sel_a = 2'd1;
                dp_sel_b = 2'd3;
                dp_alu_op = 1'b1;
                state_d = C1;
            end
            C1: begin
                dp_ld_b = 1'b1;
                dp_ld_alu_out = 1'b1;
                dp_sel_a = 2'd1;
                dp_sel_b = 2'd0;
                state_d = C2;
            end
            C2: begin
                dp_ld_a = 1'b1;
                dp_ld_alu_out = 1'b1;
                dp_sel_a = 2'd3;
                dp_sel_b = 2'd3;
                dp_alu_op = 1'b1;
                state_d = C3;
            end
            C3: begin
                dp_ld_a = 1'b1;
                dp_ld_alu_out = 1'b1;
                dp_sel_a = 2'd0;
                dp_sel_b = 2'd2;
                dp_alu_op = 1'b1;
                state_d = C4;
            end
            C4: begin
                dp_ld_r = 1'b1;
                dp_sel_a = 2'd0;
                dp_sel_b = 2'd1;
                state_d = RESP;
            end
            RESP: state_d = res_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            job_q <= '0;
            id_q <= 1'b0;
            last_grant_q <= 1'b1;
            job_count_q <= '0;
        end else begin
            state_q <= state_d;
            job_q <= job_d;
            id_q <= id_d;
            last_grant_q <= last_grant_d;
            job_count_q <= job_count_d;
        end
    end
endmodule

// File: tb/tb_poly_job_scheduler.sv
// tb_poly_job_scheduler: job-level reference model plus datapath stand-in checking poly_job_scheduler every cycle
module tb_poly_job_scheduler;
    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req_data0, req_data1;
    logic        res_valid, res_ready, res_id, busy;
    logic [7:0]  res_data, job_count, dp_data_in, dp_data_result;
    logic        dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out, dp_alu_op;
    logic [1:0]  dp_sel_a, dp_sel_b;
    int          n_cmp = 0, n_err = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    poly_job_scheduler #(.W(8), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy),
        .job_count(job_count), .dp_data_in(dp_data_in), .dp_ld_a(dp_ld_a),
        .dp_ld_b(dp_ld_b), .dp_ld_c(dp_ld_c), .dp_ld_x(dp_ld_x), .dp_ld_r(dp_ld_r),
        .dp_ld_alu_out(dp_ld_alu_out), .dp_sel_a(dp_sel_a), .dp_sel_b(dp_sel_b),
        .dp_alu_op(dp_alu_op), .dp_data_result(dp_data_result)
    );

    // Stand-in datapath: four operand registers, result register, add/mul ALU
    logic [7:0] ra = 0, rb = 0, rc = 0, rx = 0, rr = 0, oa, ob, alu, v;
    assign oa = dp_sel_a == 2'd0 ? ra : dp_sel_a == 2'd1 ? rb : dp_sel_a == 2'd2 ? rc : rx;
    assign ob = dp_sel_b == 2'd0 ? ra : dp_sel_b == 2'd1 ? rb : dp_sel_b == 2'd2 ? rc : rx;
    assign alu = dp_alu_op ? oa * ob : oa + ob;
    assign v = dp_ld_alu_out ? alu : dp_data_in;
    assign dp_data_result = rr;
    always @(posedge clk) begin
        if (dp_ld_a) ra <= v;
        if (dp_ld_b) rb <= v;
        if (dp_ld_c) rc <= v;
        if (dp_ld_x) rx <= v;
        if (dp_ld_r) rr <= alu;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] poly(input logic [31:0] j);
        logic [7:0] a, b, c, x, bx, xx;
        {a, b, c, x} = j;
        bx = b * x;
        xx = x * x;
        return a + bx + xx * c;
    endfunction

    // Expected {ld_a,ld_b,ld_c,ld_x,ld_r,ld_alu_out,sel_a,sel_b,op} for cycle p after accept
    function automatic logic [10:0] ctl(input int p);
        case (p)
            1: return 11'b10000_0_00_00_0;
            2: return 11'b01000_0_00_00_0;
            3: return 11'b00100_0_00_00_0;
            4: return 11'b00010_0_00_00_0;
            5: return 11'b01000_1_01_11_1;
            6: return 11'b01000_1_01_00_0;
            7: return 11'b10000_1_11_11_1;
            8: return 11'b10000_1_00_10_1;
            9: return 11'b00001_0_00_01_0;
            default: return 11'b0;
        endcase
    endfunction

    // Job-level model: phase 0 idle, 1..9 cycles after accept, 10 waiting for result handshake
    logic        armed = 1'b0, mid = 1'b0, mlast = 1'b1;
    logic [31:0] mjob = 0;
    logic [7:0]  mcount = 0, mres = 0;
    int          phase = 0, comp = 0;
    int          grants[$];
    always @(negedge clk) begin
        logic gb;
        logic [1:0] er;
        logic [7:0] ed;
        gb = (req_valid == 2'b10) || (req_valid == 2'b11 && !mlast);
        if (armed) begin
            er = (phase == 0 && |req_valid) ? (gb ? 2'b10 : 2'b01) : 2'b00;
            ed = phase == 1 ? mjob[31:24] : phase == 2 ? mjob[23:16] :
                 phase == 3 ? mjob[15:8] : phase == 4 ? mjob[7:0] : 8'h0;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(phase != 0));
            chk("res_valid", 32'(res_valid), 32'(phase == 10));
            chk("res_data", 32'(res_data), 32'(phase == 10 ? mres : 8'h0));
            chk("res_id", 32'(res_id), 32'(phase == 10 && mid));
            chk("job_count", 32'(job_count), 32'(mcount));
            chk("dp_ctl", 32'({dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out,
                               dp_sel_a, dp_sel_b, dp_alu_op}), 32'(ctl(phase)));
            chk("dp_data_in", 32'(dp_data_in), 32'(ed));
        end
        if (!resetn) begin
            armed = 1'b1;
            phase = 0;
            mlast = 1'b1;
            mcount = 0;
        end else if (armed) begin
            if (phase == 0 && |req_valid) begin
                mjob = gb ? req_data1 : req_data0;
                mid = gb;
                mlast = gb;
                mres = poly(mjob);
                grants.push_back(int'(gb));
                phase = 1;
            end else if (phase == 10) begin
                if (res_ready) begin
                    mcount++;
                    comp++;
                    phase = 0;
                end
            end else if (phase != 0) begin
                phase++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        int t0, lat, c0;
        resetn = 1'b0;
        req_valid = 2'b00;
        req_data0 = 0;
        req_data1 = 0;
        res_ready = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(job_count), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        // T1: basic job from requester 0
        step();
        req_valid = 2'b01;
        req_data0 = {8'd3, 8'd2, 8'd1, 8'd4};
        res_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 1);
        t0 = cyc;
        step();
        req_valid = 2'b00;
        req_data0 = '1;
        wait_res(t0, lat);
        chk("t1_latency", lat, 10);
        chk("t1_data", 32'(res_data), 'h1B);
        chk("t1_id", 32'(res_id), 0);
        step();
        chk("t1_count", 32'(job_count), 1);
        // T3: per-op wrap
        req_valid = 2'b01;
        req_data0 = {8'h10, 8'h10, 8'h10, 8'h10};
        @(negedge clk);
        t0 = cyc;
        step();
        req_valid = 2'b00;
        wait_res(t0, lat);
        chk("t3_latency", lat, 10);
        chk("t3_data", 32'(res_data), 'h10);
        step();
        chk("t3_count", 32'(job_count), 2);
        // T4: result backpressure from requester 1
        req_valid = 2'b10;
        req_data1 = {8'd1, 8'd1, 8'd1, 8'd1};
        res_ready = 1'b0;
        @(negedge clk);
        chk("t4_ready", 32'(req_ready), 2);
        t0 = cyc;
        step();
        req_valid = 2'b00;
        wait_res(t0, lat);
        chk("t4_latency", lat, 10);
        repeat (5) begin
            step();
            req_valid = 2'b11;
            @(negedge clk);
            chk("t4_hold_valid", 32'(res_valid), 1);
            chk("t4_hold_data", 32'(res_data), 3);
            chk("t4_hold_id", 32'(res_id), 1);
            chk("t4_hold_ready", 32'(req_ready), 0);
            chk("t4_hold_count", 32'(job_count), 2);
        end
        step();
        req_valid = 2'b00;
        res_ready = 1'b1;
        step();
        chk("t4_count", 32'(job_count), 3);
        chk("t4_idle", 32'(busy), 0);
        // T2: both requesters always valid -> alternate grants
        grants.delete();
        req_valid = 2'b11;
        for (int i = 0; i < 200; i++) begin
            step();
            if (grants.size() >= 4) break;
            req_data0 = $urandom;
            req_data1 = $urandom;
        end
        req_valid = 2'b00;
        chk("t2_njobs", grants.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_grant", i < grants.size() ? grants[i] : 99, i % 2);
        for (int i = 0; i < 30 && busy; i++) step();
        chk("t2_drain", 32'(busy), 0);
        chk("t2_count", 32'(job_count), 7);
        // T5: reset while in C2
        req_valid = 2'b01;
        req_data0 = {8'd5, 8'd6, 8'd7, 8'd8};
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 1);
        step();
        req_valid = 2'b00;
        repeat (6) step();
        resetn = 1'b0;
        @(negedge clk);
        chk("t5_c2_busy", 32'(busy), 1);
        chk("t5_c2_ctl", 32'({dp_ld_a, dp_ld_alu_out, dp_sel_a, dp_sel_b, dp_alu_op}), 'b1111111);
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_count", 32'(job_count), 0);
        repeat (15) begin
            @(negedge clk);
            chk("t5_no_res", 32'(res_valid), 0);
        end
        // T6: random traffic until the counter wraps
        c0 = comp;
        for (int i = 0; i < 30000; i++) begin
            step();
            if (comp - c0 >= 256) break;
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = $urandom;
            req_data1 = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
        end
        chk("t6_jobs", comp - c0, 256);
        chk("t6_wrap", 32'(job_count), 0);
        req_valid = 2'b00;
        res_ready = 1'b1;
        for (int i = 0; i < 30 && busy; i++) step();
        chk("t6_drain", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
